crc_engine_arbiter: RTL
=======================

CRC_ENGINE_ARBITER -- requirements
Module: crc_engine_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one CRC generator engine (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 12, meaning data word width passed to the engine.
REQ-003 SHALL have parameter CRC_WIDTH, default 4, meaning CRC result width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning watchdog limit in S_WAIT (used only with CRC_ARB_TIMEOUT_EN).
REQ-005 SHALL have ports, as listed:
  clk  in  1  single clock, all logic on posedge
  rst_n  in  1  reset, asynchronous, active-low
  req_valid  in  NUM_REQ  per-requester request
  req_data  in  NUM_REQ*DATA_WIDTH  packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
  req_ready  out  NUM_REQ  one-hot accept, combinational
  rsp_valid  out  NUM_REQ  one-hot, one-cycle result pulse
  rsp_crc  out  CRC_WIDTH  result, valid with rsp_valid
  rsp_err  out  1  timeout flag, valid with rsp_valid
  eng_start  out  1  one-cycle start pulse to engine
  eng_data  out  DATA_WIDTH  registered data to engine
  eng_crc  in  CRC_WIDTH  engine result
  eng_done  in  1  engine done level
  busy  out  1  high in any state except S_IDLE
REQ-006 Clock and reset SHALL be exactly one clock (clk) and asynchronous active-low reset (rst_n); no other clock or reset.

Function
REQ-007 FSM states SHALL be S_IDLE, S_START, S_WAIT, S_RESP.
REQ-008 S_IDLE: if any req_valid, grant g = first set req_valid at or after rr_ptr (wrapping); req_ready[g]=1 that cycle only; capture req_data slice g into eng_data and g into grant_q; -> S_START.
REQ-009 req_ready SHALL be all-zero outside S_IDLE and in S_IDLE with no req_valid.
REQ-010 S_START: eng_start=1 for exactly one cycle; -> S_WAIT.
REQ-011 S_WAIT: on rising edge of eng_done (eng_done=1, registered eng_done_q=0), capture eng_crc, -> S_RESP; a done level held from a previous job SHALL NOT complete the job.
REQ-012 S_RESP: rsp_valid[grant_q]=1 one cycle, rsp_crc=captured CRC; rr_ptr <= (grant_q+1) mod NUM_REQ; -> S_IDLE.
REQ-013 Latency: accept at cycle T, eng_start at T+1, rsp_valid one cycle after the cycle eng_done rises; back-to-back accept possible the cycle after S_RESP.
REQ-014 Requester deasserting req_valid before grant SHALL lose nothing; arbiter holds no state for it.
REQ-015 rsp_crc and rsp_err SHALL hold their last value between responses.

Reset
REQ-016 rst_n low SHALL force, at any time including mid-job: state S_IDLE, rr_ptr=0, grant_q=0, eng_data=0, eng_start=0, rsp_valid=0, rsp_crc=0, rsp_err=0, eng_done_q=0, timeout counter=0; busy=0; the job in flight is dropped without a response.

Configuration
REQ-017 With CRC_ARB_TIMEOUT_EN defined: counter cleared entering S_WAIT, incremented each S_WAIT cycle; at TIMEOUT_CYCLES without done -> S_RESP with rsp_err=1, rsp_crc=0; normal completion gives rsp_err=0.
REQ-018 Without CRC_ARB_TIMEOUT_EN: no counter, S_WAIT waits indefinitely, rsp_err tied 0, port retained.

Structure
REQ-019 State enum crc_arb_state_t and default parameter constants SHALL live in shared package crc_pkg.
REQ-020 Round-robin grant logic SHALL be sub-module rr_arbiter (req vector + pointer in, one-hot grant + index out, combinational).

Verification (bench engine model: done rises 14 cycles after start, returns 0xA)
REQ-021 Single req: req_valid=4'b0001, data 0x123 -> req_ready[0] at T, eng_start at T+1 with eng_data=0x123, rsp_valid[0] with rsp_crc=0xA, rsp_err=0.
REQ-022 Fairness: req_valid=4'b1111 held -> grants in order 0,1,2,3,0; each rsp_valid one-hot to the granted index.
REQ-023 Wrap: rr_ptr=3, req_valid=4'b0101 -> grant 0, next grant 2.
REQ-024 Stale done: eng_done held 1 from prior job -> no completion until done falls and rises again.
REQ-025 Reset mid-job: rst_n low during S_WAIT -> all outputs 0, no rsp_valid, next request granted from index 0.
REQ-026 Timeout (macro defined, TIMEOUT_CYCLES=64): engine never raises done -> rsp_valid at S_WAIT cycle 64 with rsp_err=1, rsp_crc=0.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and default configuration for the CRC engine arbiter.
// The optional S_WAIT watchdog is enabled by defining CRC_ARB_TIMEOUT_EN.
package crc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } crc_arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 12;
    localparam int DEF_CRC_WIDTH      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/crc_engine_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Requests at or above ptr are tried first; if none, the full vector is used.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick;

    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper_mask[i] = (IDX_W'(i) >= ptr);
        end
        masked = req & upper_mask;
        pick   = (|masked) ? masked : req;
        // Isolate the lowest set bit of the chosen vector.
        grant  = pick & (~pick + NUM_REQ'(1));
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/crc_engine_arbiter.sv
// Shares one CRC engine among NUM_REQ requesters with round-robin arbitration.
// Defining CRC_ARB_TIMEOUT_EN adds a watchdog that ends S_WAIT with rsp_err=1.
module crc_engine_arbiter
    import crc_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CRC_WIDTH      = DEF_CRC_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [CRC_WIDTH-1:0]          rsp_crc,
    output logic                          rsp_err,
    output logic                          eng_start,
    output logic [DATA_WIDTH-1:0]         eng_data,
    input  logic [CRC_WIDTH-1:0]          eng_crc,
    input  logic                          eng_done,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    crc_arb_state_t       state;
    crc_arb_state_t       state_next;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_q;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic [CRC_WIDTH-1:0] crc_q;
    logic                 err_q;
    logic                 eng_done_q;
    logic                 any_req;
    logic                 done_rise;
    logic                 timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign any_req   = |req_valid;
    // Only a fresh 0->1 transition completes a job; a held level does not.
    assign done_rise = eng_done & ~eng_done_q;

`ifdef CRC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == S_WAIT) && !done_rise &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_req) state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT:  if (done_rise || timeout_hit) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign req_ready = (state == S_IDLE) ? arb_grant : '0;
    assign eng_start = (state == S_START);
    assign rsp_valid = (state == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign busy      = (state != S_IDLE);
    assign rsp_crc   = crc_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            grant_q    <= '0;
            eng_data   <= '0;
            crc_q      <= '0;
            err_q      <= 1'b0;
            eng_done_q <= 1'b0;
        end else begin
            state      <= state_next;
            eng_done_q <= eng_done;
            if (state == S_IDLE && any_req) begin
                grant_q  <= arb_idx;
                eng_data <= req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state == S_WAIT) begin
                if (done_rise) begin
                    crc_q <= eng_crc;
                    err_q <= 1'b0;
                end else if (timeout_hit) begin
                    crc_q <= '0;
                    err_q <= 1'b1;
                end
            end
            if (state == S_RESP) begin
                rr_ptr <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            end
        end
    end

endmodule
